inst_fetch_arbiter: RTL and testbench

Shares one instruction-memory port between the way0 and way1 fetch units of the dual-issue core. It replaces the per-way instruction ROM ports. The arbiter picks one requester round-robin and holds the memory request until the data returns. It then delivers the instruction to the owning way with a registered `dataOk` pulse. A jump clear on the owning way squashes its in-flight fetch.

---
 rtl/inst_fetch_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_inst_fetch_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// inst_fetch_arbiter
//
// Shares a single instruction-memory port between the way0 and way1 fetch
// units of the dual-issue core. One requester is granted round-robin, the
// memory request is held until the memory answers, and the returned
// instruction is handed to the owning way with a registered one-cycle
// dataOk pulse. A jump clear on the owning way squashes its in-flight fetch.
//
// Optional feature macro: INST_FETCH_ARB_TIMEOUT_EN
//   When defined, a watchdog counter aborts an access that has been BUSY
//   for TIMEOUT_CYCLES+1 cycles and pulses timeout_o. When undefined, no
//   counter is built and timeout_o is tied to 0.
//
// Parameters:
//   TIMEOUT_CYCLES  watchdog limit (only used with the macro)
//   CNT_W           watchdog counter width, TIMEOUT_CYCLES < 2**CNT_W
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   wayN_request_i                level fetch request, held until dataOk
//   wayN_instAddr_i               fetch address, stable while requesting
//   wayN_jumpClear_i              pipeline flush for that way
//   wayN_inst_o / wayN_dataOk_o   delivered instruction / one-cycle strobe
//   mem_request_o                 memory request, high for the whole access
//   mem_instAddr_o                latched fetch address
//   mem_inst_i / mem_dataOk_i     memory read data / completion pulse
//   timeout_o                     one-cycle watchdog abort pulse
// ---------------------------------------------------------------------------
module inst_fetch_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        way0_request_i,
    input  logic [31:0] way0_instAddr_i,
    input  logic        way0_jumpClear_i,
    output logic [31:0] way0_inst_o,
    output logic        way0_dataOk_o,

    input  logic        way1_request_i,
    input  logic [31:0] way1_instAddr_i,
    input  logic        way1_jumpClear_i,
    output logic [31:0] way1_inst_o,
    output logic        way1_dataOk_o,

    output logic        mem_request_o,
    output logic [31:0] mem_instAddr_o,
    input  logic [31:0] mem_inst_i,
    input  logic        mem_dataOk_i,

    output logic        timeout_o
);

    // The watchdog counter must be able to hold the limit value.
    if (TIMEOUT_CYCLES >= (2 ** CNT_W)) begin : gBadCfg
        $error("inst_fetch_arbiter: TIMEOUT_CYCLES must be below 2**CNT_W");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q;
    logic        owner_q;
    logic        last_q;
    logic        squash_q;
    logic [31:0] addr_q;
    logic [31:0] way0Inst_q;
    logic [31:0] way1Inst_q;
    logic        way0Ok_q;
    logic        way1Ok_q;

    logic        way0Eff;
    logic        way1Eff;
    logic        grantWay;
    logic        ownerClear;

    // A way whose dataOk is high right now is about to drop its request,
    // so it is masked to avoid granting it a second, stale fetch.
    assign way0Eff = way0_request_i & ~way0_jumpClear_i & ~way0Ok_q;
    assign way1Eff = way1_request_i & ~way1_jumpClear_i & ~way1Ok_q;

    // On a tie the way that was not granted last wins; otherwise the single
    // requester wins (way1Eff alone selects way1).
    assign grantWay = (way0Eff & way1Eff) ? ~last_q : way1Eff;

    assign ownerClear = owner_q ? way1_jumpClear_i : way0_jumpClear_i;

`ifdef INST_FETCH_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
`endif

    // Arbitration FSM. All outputs are registers updated here; the pulse
    // registers default to 0 every cycle so they are high for one cycle.
    // Returned data is dropped if the owner was cleared at any point during
    // the access, including the completion cycle itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            squash_q   <= 1'b0;
            addr_q     <= '0;
            way0Inst_q <= '0;
            way1Inst_q <= '0;
            way0Ok_q   <= 1'b0;
            way1Ok_q   <= 1'b0;
`ifdef INST_FETCH_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            way0Ok_q <= 1'b0;
            way1Ok_q <= 1'b0;
`ifdef INST_FETCH_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (way0Eff | way1Eff) begin
                        owner_q  <= grantWay;
                        last_q   <= grantWay;
                        addr_q   <= grantWay ? way1_instAddr_i : way0_instAddr_i;
                        squash_q <= 1'b0;
                        state_q  <= BUSY;
`ifdef INST_FETCH_ARB_TIMEOUT_EN
                        cnt_q    <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (ownerClear) begin
                        squash_q <= 1'b1;
                    end
                    if (mem_dataOk_i) begin
                        state_q <= IDLE;
                        if (!squash_q && !ownerClear) begin
                            if (owner_q) begin
                                way1Inst_q <= mem_inst_i;
                                way1Ok_q   <= 1'b1;
                            end else begin
                                way0Inst_q <= mem_inst_i;
                                way0Ok_q   <= 1'b1;
                            end
                        end
                    end
`ifdef INST_FETCH_ARB_TIMEOUT_EN
                    // Completion in the limit cycle takes priority above.
                    else if (cnt_q == TIMEOUT_LIM) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_request_o  = (state_q == BUSY);
    assign mem_instAddr_o = addr_q;
    assign way0_inst_o    = way0Inst_q;
    assign way1_inst_o    = way1Inst_q;
    assign way0_dataOk_o  = way0Ok_q;
    assign way1_dataOk_o  = way1Ok_q;

`ifdef INST_FETCH_ARB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_arbiter
//
// Self-checking bench for inst_fetch_arbiter: a table of directed cycles
// with hand-derived expectations, a few hand-written multi-cycle sequences
// (watchdog, asynchronous reset) and a randomized phase compared every
// cycle against a transaction-level reference model.
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, half a cycle away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_inst_fetch_arbiter;

    localparam int TO = 4;
`ifdef INST_FETCH_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        way0_request_i = 1'b0;
    logic [31:0] way0_instAddr_i = '0;
    logic        way0_jumpClear_i = 1'b0;
    logic [31:0] way0_inst_o;
    logic        way0_dataOk_o;
    logic        way1_request_i = 1'b0;
    logic [31:0] way1_instAddr_i = '0;
    logic        way1_jumpClear_i = 1'b0;
    logic [31:0] way1_inst_o;
    logic        way1_dataOk_o;
    logic        mem_request_o;
    logic [31:0] mem_instAddr_o;
    logic [31:0] mem_inst_i = '0;
    logic        mem_dataOk_i = 1'b0;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    inst_fetch_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .way0_request_i(way0_request_i),
        .way0_instAddr_i(way0_instAddr_i),
        .way0_jumpClear_i(way0_jumpClear_i),
        .way0_inst_o(way0_inst_o),
        .way0_dataOk_o(way0_dataOk_o),
        .way1_request_i(way1_request_i),
        .way1_instAddr_i(way1_instAddr_i),
        .way1_jumpClear_i(way1_jumpClear_i),
        .way1_inst_o(way1_inst_o),
        .way1_dataOk_o(way1_dataOk_o),
        .mem_request_o(mem_request_o),
        .mem_instAddr_o(mem_instAddr_o),
        .mem_inst_i(mem_inst_i),
        .mem_dataOk_i(mem_dataOk_i),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0;
        logic        r1;
        logic        c0;
        logic        c1;
        logic        mok;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] minst;
    } in_t;

    typedef struct {
        logic        rst;
        in_t         in;
        logic [99:0] exp;
    } vec_t;

    // Reference model: one pending access record plus per-way delivery state.
    bit          mBusy;
    int          mOwner;
    int          mLast;
    bit          mKilled;
    int          mBusyCycles;
    logic [31:0] mAddr;
    logic [31:0] mInst[2];
    bit          mOk[2];
    bit          mTimeout;

    function automatic in_t mkIn(int r0, logic [31:0] a0, int c0,
                                 int r1, logic [31:0] a1, int c1,
                                 int mok, logic [31:0] minst);
        in_t s;
        s.r0 = (r0 != 0);
        s.a0 = a0;
        s.c0 = (c0 != 0);
        s.r1 = (r1 != 0);
        s.a1 = a1;
        s.c1 = (c1 != 0);
        s.mok = (mok != 0);
        s.minst = minst;
        return s;
    endfunction

    function automatic logic [99:0] mkExp(int req, logic [31:0] addr, int ok0, int ok1,
                                          logic [31:0] i0, logic [31:0] i1);
        return {(req != 0), addr, i0, i1, (ok0 != 0), (ok1 != 0), 1'b0};
    endfunction

    function automatic vec_t row(int rst, in_t s, logic [99:0] exp);
        vec_t v;
        v.rst = (rst != 0);
        v.in = s;
        v.exp = exp;
        return v;
    endfunction

    function automatic logic [99:0] actualVec();
        return {mem_request_o, mem_instAddr_o, way0_inst_o, way1_inst_o,
                way0_dataOk_o, way1_dataOk_o, timeout_o};
    endfunction

    function automatic logic [99:0] modelVec();
        return {mBusy, mAddr, mInst[0], mInst[1], mOk[0], mOk[1], mTimeout};
    endfunction

    task automatic modelReset();
        mBusy = 0;
        mOwner = 0;
        mLast = 1;
        mKilled = 0;
        mBusyCycles = 0;
        mAddr = '0;
        mInst[0] = '0;
        mInst[1] = '0;
        mOk[0] = 0;
        mOk[1] = 0;
        mTimeout = 0;
    endtask

    // Advances the model across one rising edge given the inputs of the cycle.
    task automatic modelStep(input in_t s);
        bit          want[2];
        bit          clr[2];
        logic [31:0] adr[2];
        bit          nextOk[2];
        bit          nextTo;
        int          pick;
        clr[0] = s.c0;
        clr[1] = s.c1;
        adr[0] = s.a0;
        adr[1] = s.a1;
        want[0] = s.r0 && !s.c0 && !mOk[0];
        want[1] = s.r1 && !s.c1 && !mOk[1];
        nextOk[0] = 0;
        nextOk[1] = 0;
        nextTo = 0;
        if (!mBusy) begin
            if (want[0] || want[1]) begin
                if (want[0] && want[1]) pick = 1 - mLast;
                else pick = want[1] ? 1 : 0;
                mBusy = 1;
                mOwner = pick;
                mLast = pick;
                mKilled = 0;
                mBusyCycles = 1;
                mAddr = adr[pick];
            end
        end else if (s.mok) begin
            if (!mKilled && !clr[mOwner]) begin
                mInst[mOwner] = s.minst;
                nextOk[mOwner] = 1;
            end
            mBusy = 0;
        end else if (TIMEOUT_EN && mBusyCycles == TO + 1) begin
            nextTo = 1;
            mBusy = 0;
        end else begin
            mBusyCycles++;
            if (clr[mOwner]) mKilled = 1;
        end
        mOk[0] = nextOk[0];
        mOk[1] = nextOk[1];
        mTimeout = nextTo;
    endtask

    task automatic applyStimulus(input in_t s);
        way0_request_i   = s.r0;
        way0_instAddr_i  = s.a0;
        way0_jumpClear_i = s.c0;
        way1_request_i   = s.r1;
        way1_instAddr_i  = s.a1;
        way1_jumpClear_i = s.c1;
        mem_dataOk_i     = s.mok;
        mem_inst_i       = s.minst;
        @(posedge clk);
        modelStep(s);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [99:0] exp);
        logic [99:0] act;
        act = actualVec();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (req,addr,inst0,inst1,ok0,ok1,to)",
                     name, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        applyIdleInputs();
        #1;
        checkOutput("reset state", '0);
        @(negedge clk);
        reset_n = 1'b1;
        modelReset();
    endtask

    task automatic applyIdleInputs();
        way0_request_i   = 1'b0;
        way0_jumpClear_i = 1'b0;
        way1_request_i   = 1'b0;
        way1_jumpClear_i = 1'b0;
        mem_dataOk_i     = 1'b0;
    endtask

    vec_t        vecs[$];
    bit          curReq[2];
    logic [31:0] curAddr[2];

    initial begin
        in_t s;
        int  firstTo;
        int  pulses;
        int  reqLate;

        modelReset();

        // Single requester, memory answers two cycles after the request.
        vecs.push_back(row(1, mkIn(1,32'h8000_0000,0, 0,32'h0,0, 0,32'h0), mkExp(1,32'h8000_0000,0,0,32'h0,32'h0)));
        vecs.push_back(row(0, mkIn(1,32'h8000_0000,0, 0,32'h0,0, 0,32'h0), mkExp(1,32'h8000_0000,0,0,32'h0,32'h0)));
        vecs.push_back(row(0, mkIn(1,32'h8000_0000,0, 0,32'h0,0, 1,32'h13), mkExp(0,32'h8000_0000,1,0,32'h13,32'h0)));
        vecs.push_back(row(0, mkIn(0,32'h8000_0000,0, 0,32'h0,0, 0,32'h0), mkExp(0,32'h8000_0000,0,0,32'h13,32'h0)));
        // Both ways requesting, 1-cycle memory: strict alternation.
        vecs.push_back(row(1, mkIn(1,32'h100,0, 1,32'h200,0, 0,32'h0), mkExp(1,32'h100,0,0,32'h0,32'h0)));
        vecs.push_back(row(0, mkIn(1,32'h100,0, 1,32'h200,0, 1,32'hA0A0_0000), mkExp(0,32'h100,1,0,32'hA0A0_0000,32'h0)));
        vecs.push_back(row(0, mkIn(1,32'h100,0, 1,32'h200,0, 0,32'h0), mkExp(1,32'h200,0,0,32'hA0A0_0000,32'h0)));
        vecs.push_back(row(0, mkIn(1,32'h100,0, 1,32'h200,0, 1,32'hA1A1_1111), mkExp(0,32'h200,0,1,32'hA0A0_0000,32'hA1A1_1111)));
        vecs.push_back(row(0, mkIn(1,32'h100,0, 1,32'h200,0, 0,32'h0), mkExp(1,32'h100,0,0,32'hA0A0_0000,32'hA1A1_1111)));
        vecs.push_back(row(0, mkIn(1,32'h100,0, 1,32'h200,0, 1,32'hA2A2_2222), mkExp(0,32'h100,1,0,32'hA2A2_2222,32'hA1A1_1111)));
        vecs.push_back(row(0, mkIn(1,32'h100,0, 1,32'h200,0, 0,32'h0), mkExp(1,32'h200,0,0,32'hA2A2_2222,32'hA1A1_1111)));
        vecs.push_back(row(0, mkIn(1,32'h100,0, 1,32'h200,0, 1,32'hA3A3_3333), mkExp(0,32'h200,0,1,32'hA2A2_2222,32'hA3A3_3333)));
        // way1 owner squashed by its clear; way0 served next.
        vecs.push_back(row(1, mkIn(0,32'h0,0, 1,32'h300,0, 0,32'h0), mkExp(1,32'h300,0,0,32'h0,32'h0)));
        vecs.push_back(row(0, mkIn(0,32'h0,0, 1,32'h300,0, 1,32'h11), mkExp(0,32'h300,0,1,32'h0,32'h11)));
        vecs.push_back(row(0, mkIn(0,32'h0,0, 0,32'h300,0, 0,32'h0), mkExp(0,32'h300,0,0,32'h0,32'h11)));
        vecs.push_back(row(0, mkIn(0,32'h0,0, 1,32'h300,0, 0,32'h0), mkExp(1,32'h300,0,0,32'h0,32'h11)));
        vecs.push_back(row(0, mkIn(1,32'h400,0, 0,32'h300,1, 0,32'h0), mkExp(1,32'h300,0,0,32'h0,32'h11)));
        vecs.push_back(row(0, mkIn(1,32'h400,0, 0,32'h0,0, 1,32'hDEAD), mkExp(0,32'h300,0,0,32'h0,32'h11)));
        vecs.push_back(row(0, mkIn(1,32'h400,0, 0,32'h0,0, 0,32'h0), mkExp(1,32'h400,0,0,32'h0,32'h11)));
        vecs.push_back(row(0, mkIn(1,32'h400,0, 0,32'h0,0, 1,32'h55), mkExp(0,32'h400,1,0,32'h55,32'h11)));
        vecs.push_back(row(0, mkIn(0,32'h400,0, 0,32'h0,0, 0,32'h0), mkExp(0,32'h400,0,0,32'h55,32'h11)));
        // Owner clear coincident with completion drops data; non-owner clear does not.
        vecs.push_back(row(0, mkIn(1,32'h500,0, 0,32'h0,0, 0,32'h0), mkExp(1,32'h500,0,0,32'h55,32'h11)));
        vecs.push_back(row(0, mkIn(1,32'h500,1, 0,32'h0,0, 1,32'h77), mkExp(0,32'h500,0,0,32'h55,32'h11)));
        vecs.push_back(row(0, mkIn(1,32'h500,0, 0,32'h0,0, 0,32'h0), mkExp(1,32'h500,0,0,32'h55,32'h11)));
        vecs.push_back(row(0, mkIn(1,32'h500,0, 0,32'h0,1, 1,32'h88), mkExp(0,32'h500,1,0,32'h88,32'h11)));
        vecs.push_back(row(0, mkIn(0,32'h500,0, 0,32'h0,0, 0,32'h0), mkExp(0,32'h500,0,0,32'h88,32'h11)));

        foreach (vecs[i]) begin
            if (vecs[i].rst) doReset();
            applyStimulus(vecs[i].in);
            checkOutput($sformatf("vector %0d", i), vecs[i].exp);
        end

        // Memory never answers: watchdog behaviour (or its absence).
        doReset();
        s = mkIn(1,32'h600,0, 0,32'h0,0, 0,32'h0);
        firstTo = -1;
        pulses = 0;
        reqLate = 0;
`ifdef INST_FETCH_ARB_TIMEOUT_EN
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(s);
            if (timeout_o === 1'b1) begin
                pulses++;
                if (firstTo < 0) firstTo = k;
            end
            if (k == 7) reqLate = int'(mem_request_o);
        end
        checkValue("timeout pulse cycle", firstTo, 6);
        checkValue("timeout pulse count", pulses, 1);
        checkValue("re-grant after timeout", reqLate, 1);
        checkValue("re-grant address", mem_instAddr_o, 32'h600);
`else
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(s);
            if (timeout_o !== 1'b0) pulses++;
        end
        reqLate = int'(mem_request_o);
        checkValue("timeout stays low", pulses, 0);
        checkValue("request held without watchdog", reqLate, 1);
`endif

        // Reset asserted mid-access clears outputs immediately.
        doReset();
        applyStimulus(mkIn(1,32'h700,0, 0,32'h0,0, 0,32'h0));
        checkOutput("busy before reset", mkExp(1,32'h700,0,0,32'h0,32'h0));
        #2;
        reset_n = 1'b0;
        applyIdleInputs();
        #1;
        checkOutput("async reset clears outputs", '0);
        @(negedge clk);
        reset_n = 1'b1;
        modelReset();
        applyStimulus(mkIn(1,32'h700,0, 1,32'h800,0, 0,32'h0));
        checkOutput("first tie after reset", mkExp(1,32'h700,0,0,32'h0,32'h0));
        applyStimulus(mkIn(1,32'h700,0, 1,32'h800,0, 1,32'h1234));
        checkOutput("delivery after reset", mkExp(0,32'h700,1,0,32'h1234,32'h0));
        applyStimulus(mkIn(0,32'h700,0, 1,32'h800,0, 0,32'h0));
        checkOutput("way1 after reset tie", mkExp(1,32'h800,0,0,32'h1234,32'h0));

        // Randomized traffic against the reference model.
        doReset();
        curReq[0] = 0;
        curReq[1] = 0;
        curAddr[0] = '0;
        curAddr[1] = '0;
        for (int n = 0; n < 2000; n++) begin
            bit clr[2];
            for (int w = 0; w < 2; w++) begin
                if (curReq[w] && mOk[w]) begin
                    curReq[w] = 0;
                end else if (!curReq[w] && $urandom_range(0, 2) == 0) begin
                    curReq[w] = 1;
                    curAddr[w] = $urandom & 32'hFFFF_FFFC;
                end
                clr[w] = ($urandom_range(0, 11) == 0);
                if (clr[w] && $urandom_range(0, 1) == 0) curReq[w] = 0;
            end
            s.r0 = curReq[0];
            s.a0 = curAddr[0];
            s.c0 = clr[0];
            s.r1 = curReq[1];
            s.a1 = curAddr[1];
            s.c1 = clr[1];
            s.mok = mBusy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            s.minst = $urandom;
            applyStimulus(s);
            checkOutput($sformatf("random cycle %0d", n), modelVec());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
